// File: rtl/spi_gyro_responder.sv
// SPI mode-3 slave emulating the L3G4200D gyro register map from the sensor side.
// Ports: clk/RST system clock and async high reset; sclk/ss/mosi/miso/miso_oe SPI pins
// (oversampled); temp/x/y/z_axis_data live samples; ctrl_reg1 mirror; frame_done pulse.
module spi_gyro_responder #(
  parameter logic [7:0] WHO_AM_I    = 8'hD3,
  parameter logic [7:0] CTRL1_RST   = 8'h07,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  temp_data,
  input  logic [15:0] x_axis_data,
  input  logic [15:0] y_axis_data,
  input  logic [15:0] z_axis_data,
  output logic [7:0]  ctrl_reg1,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  byte_in;
  logic [7:0]  tx;
  logic [5:0]  addr, addr_nxt;
  logic        rw, ms;
  logic [7:0]  ctrl [0:4];
  logic [7:0]  temp_sh;
  logic [15:0] x_sh, y_sh, z_sh;

  // The ss chain resets low so that a master already holding ss low when reset
  // releases produces no fall edge: that frame is ignored until ss goes high and
  // falls again.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sclk_q <= '1;
      ss_q   <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b1;
      ss_d   <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // sclk edges only count while ss is low; this also makes an ss rise win over
  // a coincident 8th sclk rise.
  assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign byte_in   = {rx_sr, mosi_s};
  assign addr_nxt  = ms ? addr + 6'd1 : addr;
  assign ctrl_reg1 = ctrl[0];

  function automatic logic [7:0] read_reg(input logic [5:0] a);
    case (a)
      6'h0F:   read_reg = WHO_AM_I;
      6'h20:   read_reg = ctrl[0];
      6'h21:   read_reg = ctrl[1];
      6'h22:   read_reg = ctrl[2];
      6'h23:   read_reg = ctrl[3];
      6'h24:   read_reg = ctrl[4];
      6'h26:   read_reg = temp_sh;
      6'h27:   read_reg = 8'h0F;
      6'h28:   read_reg = x_sh[7:0];
      6'h29:   read_reg = x_sh[15:8];
      6'h2A:   read_reg = y_sh[7:0];
      6'h2B:   read_reg = y_sh[15:8];
      6'h2C:   read_reg = z_sh[7:0];
      6'h2D:   read_reg = z_sh[15:8];
      default: read_reg = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = CMD;
      CMD:     if (sclk_rise && bit_cnt == 3'd7) state_nxt = DATA;
      default: state_nxt = state;
    endcase
    if (ss_rise) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx         <= '0;
      addr       <= '0;
      rw         <= 1'b0;
      ms         <= 1'b0;
      temp_sh    <= '0;
      x_sh       <= '0;
      y_sh       <= '0;
      z_sh       <= '0;
      ctrl[0]    <= CTRL1_RST;
      for (int i = 1; i < 5; i++) ctrl[i] <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      if (ss_rise) begin
        miso       <= 1'b0;
        miso_oe    <= 1'b0;
        bit_cnt    <= '0;
        frame_done <= (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              temp_sh <= temp_data;
              x_sh    <= x_axis_data;
              y_sh    <= y_axis_data;
              z_sh    <= z_axis_data;
              bit_cnt <= '0;
              miso_oe <= 1'b1;
              miso    <= 1'b0;
            end
          end
          CMD: begin
            // miso stays 0 throughout the command byte
            if (sclk_rise) begin
              rx_sr   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw   <= byte_in[7];
                ms   <= byte_in[6];
                addr <= byte_in[5:0];
                tx   <= read_reg(byte_in[5:0]);
              end
            end
          end
          DATA: begin
            if (sclk_fall && rw) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_sr   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rw) begin
                  case (addr)
                    6'h20:   ctrl[0] <= byte_in;
                    6'h21:   ctrl[1] <= byte_in;
                    6'h22:   ctrl[2] <= byte_in;
                    6'h23:   ctrl[3] <= byte_in;
                    6'h24:   ctrl[4] <= byte_in;
                    default: ;
                  endcase
                end
                addr <= addr_nxt;
                tx   <= read_reg(addr_nxt);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_gyro_responder.md
Name: spi_gyro_responder

Overview:
SPI slave that emulates the L3G4200D gyro register interface from the sensor side, so the gyro master/controller pair can be exercised in simulation and on-board loopback without a physical Pmod.
- Runs in the system clk domain and oversamples sclk/ss/mosi.
- Serves WHO_AM_I, CTRL_REG1..5, OUT_TEMP, STATUS and the X/Y/Z output registers from parallel sensor inputs.

Parameters:
WHO_AM_I, 8'hD3, value returned at address 0x0F
CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20)
SYNC_STAGES, 2, flip-flop depth of the sclk/ss/mosi synchronisers (min 2)

Ports:
clk  input  1  system clock; must be >= 8x the sclk frequency
RST  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master, mode 3 (CPOL=1, CPHA=1)
ss  input  1  slave select, active low
mosi  input  1  master-out data
miso  output  1  slave-out data
miso_oe  output  1  miso drive enable; high only while ss is low (synchronised)
temp_data  input  8  live temperature sample
x_axis_data  input  16  live X sample
y_axis_data  input  16  live Y sample
z_axis_data  input  16  live Z sample
ctrl_reg1  output  8  current CTRL_REG1 contents
frame_done  output  1  one-clk pulse when ss deasserts after a frame

Behaviour:
- Reset: state IDLE; miso=0, miso_oe=0, frame_done=0, ctrl_reg1=CTRL1_RST; CTRL_REG2..5 = 0x00; shadows cleared.
- Synchronisation: sclk, ss and mosi each pass through SYNC_STAGES flops. Rise/fall detection is done on the synchronised sclk, and all actions are taken in clk on the detected edges.
- SPI mode 3: mosi is sampled on sclk rise; miso is updated on sclk fall; MSB first.
- States: IDLE, CMD, DATA.
- IDLE -> CMD on synchronised ss fall:
  - snapshot temp/x/y/z into shadow registers, which hold for the whole frame;
  - bit counter = 0; miso_oe=1; miso=0.
- CMD: shift in 8 bits. On the 8th rise, latch RW=bit7 (1=read), MS=bit6 (auto-increment) and ADDR=bits5:0, then go to DATA.
  - If RW=1, preload tx shift = reg[ADDR]; miso=0 for the whole command byte.
- DATA, read:
  - on each sclk fall, miso = tx[7] and tx shifts left;
  - after the 8th rise of each byte, if MS=1 then ADDR=ADDR+1 (6-bit wrap, 0x3F->0x00), then reload tx = reg[ADDR].
- DATA, write: after the 8th rise of each byte, write the received byte if ADDR is in 0x20..0x24; otherwise discard. Then auto-increment as for reads.
- Read map:
  - 0x0F = WHO_AM_I; 0x20..0x24 = CTRL_REG1..5;
  - 0x26 = temp shadow; 0x27 = 8'h0F (STATUS, constant);
  - 0x28/0x29 = X low/high; 0x2A/0x2B = Y low/high; 0x2C/0x2D = Z low/high;
  - all other addresses read 0x00.
- Any state -> IDLE on synchronised ss rise:
  - partial byte discarded with no write; miso_oe=0, miso=0;
  - frame_done pulses for exactly 1 clk, and only if state was CMD or DATA.
- Simultaneous ss rise and 8th sclk rise in the same clk: ss wins; the byte is discarded.
- Edge guards: sclk edges while ss is high are ignored. An ss fall while already in CMD/DATA is impossible, and no check is required.
- RST mid-frame: everything returns to reset values immediately. A frame in progress is ignored until the next ss fall.
- ctrl_reg1 updates 1 clk after the write-committing sclk rise is detected.

Test Plan:
- Reset: assert RST with ss high -> miso=0, miso_oe=0, ctrl_reg1=0x07, frame_done=0.
- WHO_AM_I: frame 0x8F + 1 dummy byte, sclk=clk/16 -> second byte on miso = 0xD3; miso=0 during the command; frame_done pulses once.
- Write then read CTRL_REG1: frame 0x20,0x0F -> ctrl_reg1=0x0F. Then frame 0xA0 + dummy -> reads 0x0F.
- Burst read:
  - setup: temp=0x19, x=0x1234, y=0xABCD, z=0x8001;
  - frame 0xE6 + 8 dummy bytes -> 0x19,0x0F,0x34,0x12,0xCD,0xAB,0x01,0x80;
  - changing x mid-frame does not alter the returned bytes.
- No auto-increment and wrap:
  - 0xA8 + 3 bytes -> 0x34,0x34,0x34;
  - 0xFF + 2 bytes -> 0x00,0x00 (ADDR wraps to 0x00);
  - write 0x40 (ADDR 0x00), 0xAA,0x55 -> no register change.
- Abort: ss rises after 5 bits of a write-data byte to 0x20 -> ctrl_reg1 unchanged, state IDLE. The next 0x8F frame still returns 0xD3.
